dm_arbiter: RTL

- Two-port arbiter and sequencer for the 128x32 data memory.
- Shares the single memory port between requester 0 (CPU load/store path) and requester 1 (loader/debug port).
- Uses round-robin arbitration with a per-requester req/ack handshake.
- Registers all memory-side controls so the memory sees stable addr/rd/wr/wdata for a full cycle; the memory latches writes on negedge and reads combinationally.

---
 rtl/dm_arbiter_pkg.sv | 13 +
 rtl/dm_arbiter_rr_arb2.sv | 16 +
 rtl/dm_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: geometry and sequencer states.
package dm_arbiter_pkg;

  localparam int unsigned DM_AW = 7;
  localparam int unsigned DM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       any
);

  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
    any    = |req;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin sequencer sharing the single data-memory port between two requesters;
// every access is a fixed IDLE/ACCESS/RESP sequence with fully registered memory controls.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned AW = DM_AW,
  parameter int unsigned DW = DM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd,
  output logic          dm_wr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  dm_state_e  state;
  logic       last;
  logic       owner;
  logic [1:0] gnt;
  logic       any;

  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (last),
    .gnt  (gnt),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      dm_rd    <= 1'b0;
      dm_wr    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      rdata    <= '0;
      last     <= 1'b1;
      owner    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            // gnt is one-hot when any is set, so gnt[1] alone names the winner
            owner <= gnt[1];
            last  <= gnt[1];
            if (gnt[1]) begin
              dm_addr  <= addr1;
              dm_wdata <= wdata1;
              dm_wr    <= wr1;
              dm_rd    <= ~wr1;
            end else begin
              dm_addr  <= addr0;
              dm_wdata <= wdata0;
              dm_wr    <= wr0;
              dm_rd    <= ~wr0;
            end
            busy  <= 1'b1;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // the memory has already latched any write at the mid-cycle negedge
          rdata <= dm_rdata;
          dm_rd <= 1'b0;
          dm_wr <= 1'b0;
          ack0  <= ~owner;
          ack1  <= owner;
          state <= ST_RESP;
        end
        ST_RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          dm_rd <= 1'b0;
          dm_wr <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
